alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares the single 3-bit-coded ALU between NUM_REQ requesters (e.g. main datapath, branch unit, address unit).
//   Round-robin arbitration, valid/ready handshake on both request and response sides.
//   Operands latched, ALU driven from registers, result captured and held until accepted.
//   Sits between requesters and the ALU; drives the ALU's operation/operand inputs.
// PARAMETERS
//   NUM_REQ     2   number of requesters (2..8)
//   DATA_WIDTH  32  operand/result width
//   IDX_W       3   grant-index width; must be >= clog2(NUM_REQ)
// PORTS
//   clk           in   1                   rising-edge clock
//   reset         in   1                   synchronous, active-high
//   req_valid     in   NUM_REQ             per-requester request valid
//   req_ready     out  NUM_REQ             per-requester accept (one-hot or zero)
//   req_op        in   3*NUM_REQ           op code, requester i at [3i+2:3i]
//   req_a         in   DATA_WIDTH*NUM_REQ  operand A, requester i at slice i
//   req_b         in   DATA_WIDTH*NUM_REQ  operand B, requester i at slice i
//   alu_operation out  3                   to ALU operation input
//   alu_a         out  DATA_WIDTH          to ALU operand A
//   alu_b         out  DATA_WIDTH          to ALU operand B
//   alu_result    in   DATA_WIDTH          from ALU (combinational)
//   alu_zero      in   1                   from ALU zero flag
//   rsp_valid     out  NUM_REQ             response valid, one-hot to owner
//   rsp_ready     in   NUM_REQ             per-requester response accept
//   rsp_data      out  DATA_WIDTH          result, shared bus
//   rsp_zero      out  1                   zero flag of result
//   rsp_err       out  1                   1 = illegal op code, rsp_data = 0
// BEHAVIOUR
//   Op codes: AND=000 OR=001 NOR=010 ADD=011 SUB=100. 101/110/111 are illegal.
//   FSM states: IDLE, EXEC, RESP.
//   IDLE:
//     - Grant g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     - req_ready[g] = 1 combinationally, same cycle; all other req_ready bits = 0.
//     - On handshake: latch op/a/b into op_q/a_q/b_q and g into gnt_q.
//     - Legal op -> EXEC. Illegal op -> RESP with err_q=1, data_q=0, zero_q=0.
//   EXEC (exactly 1 cycle):
//     - alu_operation=op_q, alu_a=a_q, alu_b=b_q (all registered).
//     - Capture data_q <= alu_result, zero_q <= alu_zero, err_q <= 0; go to RESP.
//   RESP:
//     - rsp_valid[gnt_q]=1; rsp_data/rsp_zero/rsp_err held stable.
//     - Stay until rsp_ready[gnt_q]. On handshake: rr_ptr <= (gnt_q+1) mod NUM_REQ; go to IDLE.
//     - rsp_ready of non-owners is ignored.
//   req_ready is 0 outside IDLE; no new request is accepted while one is in flight.
//   Latency: legal op, handshake cycle T -> rsp_valid at T+2. Illegal op -> rsp_valid at T+1.
//   Throughput: with immediate rsp_ready, one op per 3 cycles (legal) or 2 cycles (illegal).
//   alu_operation/alu_a/alu_b hold their last values outside EXEC; they only change on an IDLE handshake.
//   A requester may drop req_valid before its grant; the arbiter keeps no state for ungranted requests.
//   Fairness: a continuously requesting i is granted within NUM_REQ grants.
//   Reset (any state, including mid-EXEC/RESP):
//     - state=IDLE, rr_ptr=0, gnt_q=0; the in-flight operation is dropped.
//     - req_ready=0 and rsp_valid=0 during the reset cycle.
//     - alu_operation=3'b111, alu_a=0, alu_b=0.
//     - rsp_data=0, rsp_zero=0, rsp_err=0.
//   Arithmetic is the ALU's concern; this block neither widens nor truncates operands.
// TESTING
//   1. Single request: req0 ADD a=5 b=7, rsp_ready=1 -> rsp_valid[0] at T+2, rsp_data=12, rsp_zero=0.
//   2. SUB equal: req1 SUB a=b=0x1234 -> rsp_data=0, rsp_zero=1, only rsp_valid[1] high.
//   3. Contention: req0 and req1 valid continuously from reset -> grants 0,1,0,1; each completes in 3 cycles.
//   4. Backpressure: rsp_ready[0]=0 for 5 cycles after rsp_valid -> data stable; req_ready stays 0 for both requesters.
//   5. Illegal op 3'b110 -> rsp_valid at T+1, rsp_err=1, rsp_data=0; ALU outputs unchanged.
//   6. Reset asserted during EXEC -> next cycle IDLE, rsp_valid=0, alu_operation=3'b111; next request granted from index 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU; ports: req_* valid/ready/op/a/b per requester, alu_* registered ALU drive and result, rsp_* one-hot valid/ready with shared data/zero/err
module alu_share_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
  output logic [2:0]                    alu_operation,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_zero,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_zero,
  output logic                          rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] rr_ptr, gnt, gnt_q, hi, lo;
  logic hi_any, any, req_hs, rsp_hs, legal;
  logic [2:0] sel_op, op_q;
  logic [DATA_WIDTH-1:0] sel_a, sel_b, a_q, b_q, data_q;
  logic zero_q, err_q;
  always_comb begin
    hi = '0;
    lo = '0;
    hi_any = 1'b0;
    any = 1'b0;
    sel_op = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo = IDX_W'(i);
        any = 1'b1;
        if (IDX_W'(i) >= rr_ptr) begin
          hi = IDX_W'(i);
          hi_any = 1'b1;
        end
      end
    end
    gnt = hi_any ? hi : lo;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == IDX_W'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a = req_a[DATA_WIDTH*i +: DATA_WIDTH];
        sel_b = req_b[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end
  assign req_ready = (state == IDLE && any && !reset) ? NUM_REQ'(1) << gnt : '0;
  assign rsp_valid = (state == RESP && !reset) ? NUM_REQ'(1) << gnt_q : '0;
  assign req_hs = |(req_ready & req_valid);
  assign rsp_hs = |(rsp_valid & rsp_ready);
  assign legal = sel_op <= 3'd4;
  always_comb begin
    state_n = state;
    if (state == IDLE && req_hs) state_n = legal ? EXEC : RESP;
    else if (state == EXEC) state_n = RESP;
    else if (state == RESP && rsp_hs) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt_q <= '0;
      op_q <= 3'b111;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (req_hs) begin
        gnt_q <= gnt;
        if (legal) begin
          op_q <= sel_op;
          a_q <= sel_a;
          b_q <= sel_b;
        end else begin
          data_q <= '0;
          zero_q <= 1'b0;
          err_q <= 1'b1;
        end
      end
      if (state == EXEC) begin
        data_q <= alu_result;
        zero_q <= alu_zero;
        err_q <= 1'b0;
      end
      if (rsp_hs) rr_ptr <= (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
    end
  end
  assign alu_operation = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign rsp_err = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_alu_share_arbiter;
  localparam int N = 3;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [3*N-1:0] req_op = '0;
  logic [DW*N-1:0] req_a = '0, req_b = '0;
  logic [2:0] alu_operation;
  logic [DW-1:0] alu_a, alu_b, alu_result, rsp_data;
  logic alu_zero, rsp_zero, rsp_err;
  int pass = 0;
  int total = 0;

  alu_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .IDX_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a | b);
      3'd3: return a + b;
      3'd4: return a - b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_operation, alu_a, alu_b);
  assign alu_zero = (alu_result == '0);

  task automatic set_req(input int i, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_op[3*i +: 3] = op;
    req_a[DW*i +: DW] = a;
    req_b[DW*i +: DW] = b;
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) set_req(i, 3'd3, 32'd1, 32'd2);
    repeat (2) @(negedge clk);
    #1;
    total++; if (req_ready !== 3'b000) $display("FAIL reset_req_ready got=%b exp=000", req_ready); else pass++;
    total++; if (rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid got=%b exp=000", rsp_valid); else pass++;
    total++; if (alu_operation !== 3'b111) $display("FAIL reset_alu_op got=%b exp=111", alu_operation); else pass++;
    total++; if (alu_a !== 32'd0 || alu_b !== 32'd0) $display("FAIL reset_alu_ab got=%h/%h exp=0/0", alu_a, alu_b); else pass++;
    total++; if ({rsp_data, rsp_zero, rsp_err} !== 34'd0) $display("FAIL reset_rsp got=%h z=%b e=%b exp=0", rsp_data, rsp_zero, rsp_err); else pass++;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    set_req(0, 3'd3, 32'd5, 32'd7);
    req_valid = 3'b001;
    rsp_ready = 3'b111;
    #1;
    total++; if (req_ready !== 3'b001) $display("FAIL single_grant got=%b exp=001", req_ready); else pass++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 3'b000) $display("FAIL single_t1_valid got=%b exp=000", rsp_valid); else pass++;
    total++; if ({alu_operation, alu_a, alu_b} !== {3'd3, 32'd5, 32'd7}) $display("FAIL single_alu_drive got=%0d %0d %0d exp=3 5 7", alu_operation, alu_a, alu_b); else pass++;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 3'b001) $display("FAIL single_t2_valid got=%b exp=001", rsp_valid); else pass++;
    total++; if ({rsp_data, rsp_zero, rsp_err} !== {32'd12, 1'b0, 1'b0}) $display("FAIL single_data got=%0d z=%b e=%b exp=12 0 0", rsp_data, rsp_zero, rsp_err); else pass++;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 3'b000) $display("FAIL single_done got=%b exp=000", rsp_valid); else pass++;
  endtask

  task automatic test_sub_zero;
    @(negedge clk);
    set_req(1, 3'd4, 32'h1234, 32'h1234);
    req_valid = 3'b010;
    #1;
    total++; if (req_ready !== 3'b010) $display("FAIL sub_grant got=%b exp=010", req_ready); else pass++;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 3'b010) $display("FAIL sub_valid got=%b exp=010", rsp_valid); else pass++;
    total++; if ({rsp_data, rsp_zero, rsp_err} !== {32'd0, 1'b1, 1'b0}) $display("FAIL sub_data got=%h z=%b e=%b exp=0 1 0", rsp_data, rsp_zero, rsp_err); else pass++;
    @(negedge clk);
  endtask

  task automatic test_contention;
    int g_ow[8];
    int g_cy[8];
    int n;
    n = 0;
    pulse_reset();
    set_req(0, 3'd3, 32'd10, 32'd3);
    set_req(1, 3'd4, 32'd10, 32'd3);
    req_valid = 3'b011;
    rsp_ready = 3'b111;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != '0 && n < 8) begin
        g_ow[n] = (req_ready == 3'b001) ? 0 : (req_ready == 3'b010) ? 1 : 9;
        g_cy[n] = c;
        n++;
      end
      if (rsp_valid != '0) begin
        total++; if (rsp_data !== ((rsp_valid == 3'b001) ? 32'd13 : 32'd7)) $display("FAIL cont_data cyc=%0d valid=%b got=%0d", c, rsp_valid, rsp_data); else pass++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    total++; if (n !== 4) $display("FAIL cont_count got=%0d exp=4", n); else pass++;
    for (int k = 0; k < 4 && k < n; k++) begin
      total++; if (g_ow[k] !== k % 2 || g_cy[k] !== 3 * k) $display("FAIL cont_grant%0d got=req%0d@%0d exp=req%0d@%0d", k, g_ow[k], g_cy[k], k % 2, 3 * k); else pass++;
    end
  endtask

  task automatic test_backpressure;
    set_req(0, 3'd0, 32'hffff0000, 32'h0ff00ff0);
    set_req(1, 3'd1, 32'h1, 32'h2);
    req_valid = 3'b011;
    rsp_ready = 3'b010;
    #1;
    total++; if (req_ready !== 3'b001) $display("FAIL bp_grant got=%b exp=001", req_ready); else pass++;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (rsp_valid !== 3'b001 || rsp_data !== 32'h0ff00000) $display("FAIL bp_hold%0d got=%b %h exp=001 0ff00000", k, rsp_valid, rsp_data); else pass++;
      total++; if (req_ready !== 3'b000) $display("FAIL bp_ready%0d got=%b exp=000", k, req_ready); else pass++;
      @(negedge clk);
    end
    rsp_ready = 3'b001;
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 3'b001) $display("FAIL bp_release got=%b exp=001", rsp_valid); else pass++;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 3'b000) $display("FAIL bp_done got=%b exp=000", rsp_valid); else pass++;
    rsp_ready = 3'b111;
  endtask

  task automatic test_illegal;
    logic [2:0] op0;
    logic [DW-1:0] a0, b0;
    @(negedge clk);
    op0 = alu_operation;
    a0 = alu_a;
    b0 = alu_b;
    set_req(2, 3'b110, 32'hdead, 32'hbeef);
    req_valid = 3'b100;
    #1;
    total++; if (req_ready !== 3'b100) $display("FAIL ill_grant got=%b exp=100", req_ready); else pass++;
    @(negedge clk);
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 3'b100) $display("FAIL ill_t1_valid got=%b exp=100", rsp_valid); else pass++;
    total++; if ({rsp_data, rsp_zero, rsp_err} !== {32'd0, 1'b0, 1'b1}) $display("FAIL ill_rsp got=%h z=%b e=%b exp=0 0 1", rsp_data, rsp_zero, rsp_err); else pass++;
    total++; if ({alu_operation, alu_a, alu_b} !== {op0, a0, b0}) $display("FAIL ill_alu_hold got=%b %h %h exp=%b %h %h", alu_operation, alu_a, alu_b, op0, a0, b0); else pass++;
    @(negedge clk);
    #1;
    total++; if (rsp_valid !== 3'b000) $display("FAIL ill_done got=%b exp=000", rsp_valid); else pass++;
  endtask

  task automatic test_reset_exec;
    @(negedge clk);
    set_req(0, 3'd3, 32'd1, 32'd1);
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    set_req(1, 3'd3, 32'd2, 32'd2);
    req_valid = 3'b010;
    #1;
    total++; if (req_ready !== 3'b010) $display("FAIL rexec_grant got=%b exp=010", req_ready); else pass++;
    @(negedge clk);
    reset = 1'b1;
    req_valid = 3'b111;
    #1;
    total++; if (req_ready !== 3'b000 || rsp_valid !== 3'b000) $display("FAIL rexec_during got=%b/%b exp=000/000", req_ready, rsp_valid); else pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (rsp_valid !== 3'b000 || alu_operation !== 3'b111) $display("FAIL rexec_after got=%b op=%b exp=000 op=111", rsp_valid, alu_operation); else pass++;
    total++; if (req_ready !== 3'b001) $display("FAIL rexec_rr got=%b exp=001", req_ready); else pass++;
    req_valid = '0;
  endtask

  task automatic test_random;
    int last, owner, due, eg, idx;
    bit busy;
    logic [2:0] o;
    logic [DW-1:0] a, b, exp_data;
    logic exp_err, exp_zero;
    logic [N-1:0] exp_v;
    pulse_reset();
    last = N - 1;
    busy = 0;
    owner = 0;
    due = 0;
    exp_data = '0;
    exp_err = 0;
    exp_zero = 0;
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom_range(0, 7));
      rsp_ready = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
        set_req(i, 3'($urandom_range(0, 7)), a, b);
      end
      #1;
      if (!busy) begin
        eg = -1;
        for (int k = 0; k < N; k++) begin
          idx = (last + 1 + k) % N;
          if (eg < 0 && req_valid[idx]) eg = idx;
        end
        exp_v = (eg < 0) ? '0 : N'(1) << eg;
        total++; if (req_ready !== exp_v) $display("FAIL rnd_grant cyc=%0d valid=%b got=%b exp=%b", c, req_valid, req_ready, exp_v); else pass++;
        total++; if (rsp_valid !== '0) $display("FAIL rnd_idle_rsp cyc=%0d got=%b exp=000", c, rsp_valid); else pass++;
        if (eg >= 0) begin
          owner = eg;
          o = req_op[3*eg +: 3];
          exp_err = (o > 3'd4);
          exp_data = exp_err ? '0 : alu_fn(o, req_a[DW*eg +: DW], req_b[DW*eg +: DW]);
          exp_zero = !exp_err && exp_data == '0;
          due = c + (exp_err ? 1 : 2);
          busy = 1;
        end
      end else begin
        total++; if (req_ready !== '0) $display("FAIL rnd_busy_ready cyc=%0d got=%b exp=000", c, req_ready); else pass++;
        if (c < due) begin
          total++; if (rsp_valid !== '0) $display("FAIL rnd_early cyc=%0d got=%b exp=000", c, rsp_valid); else pass++;
        end else begin
          exp_v = N'(1) << owner;
          total++; if (rsp_valid !== exp_v) $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, exp_v); else pass++;
          total++; if ({rsp_data, rsp_zero, rsp_err} !== {exp_data, exp_zero, exp_err}) $display("FAIL rnd_rsp cyc=%0d got=%h z=%b e=%b exp=%h z=%b e=%b", c, rsp_data, rsp_zero, rsp_err, exp_data, exp_zero, exp_err); else pass++;
          if (rsp_ready[owner]) begin
            busy = 0;
            last = owner;
          end
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sub_zero();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
